// File: rtl/dff_sr_pkg.sv
// dff_sr_pkg: shared lane-resolve rule and sizing helpers for the set/reset flop bank pipeline
package dff_sr_pkg;

    function automatic logic resolve_lane(input logic d, input logic s, input logic r);
        return r ? 1'b0 : (s ? 1'b1 : d);
    endfunction

    function automatic int fill_w(input int depth);
        return (depth < 1) ? 1 : $clog2(depth + 1);
    endfunction

    function automatic logic [63:0] cnt_max(input int w);
        return (w >= 64) ? '1 : ((64'd1 << w) - 64'd1);
    endfunction

endpackage

// File: rtl/dff_sr_stage.sv
// dff_sr_stage: WIDTH-bit enabled register, asynchronously cleared by active-low reset
module dff_sr_stage #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n)
            q <= '0;
        else if (en)
            q <= d;
endmodule

// File: rtl/dff_sr_pipe.sv
// dff_sr_pipe: WIDTH-lane set/reset flop bank with DEPTH-stage enabled pipeline and saturating conflict counter
// DFF_SR_PIPE_ERR_MASK_EN adds a sticky per-lane conflict record on port err_mask
module dff_sr_pipe
    import dff_sr_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter int DEPTH     = 2,
    parameter int ERR_CNT_W = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 en,
    input  logic [WIDTH-1:0]     d,
    input  logic [WIDTH-1:0]     s,
    input  logic [WIDTH-1:0]     r,
    input  logic                 err_clr,
    output logic [WIDTH-1:0]     q,
    output logic                 q_vld,
    output logic                 err,
    output logic [ERR_CNT_W-1:0] err_cnt
`ifdef DFF_SR_PIPE_ERR_MASK_EN
    ,
    output logic [WIDTH-1:0]     err_mask
`endif
);
    localparam int FILL_W = fill_w(DEPTH);
    localparam logic [ERR_CNT_W-1:0] CNT_MAX = ERR_CNT_W'(cnt_max(ERR_CNT_W));

    logic [WIDTH-1:0]  res;
    logic [WIDTH-1:0]  conf_v;
    logic              conf;
    logic [WIDTH-1:0]  stage_in [DEPTH];
    logic [WIDTH-1:0]  stage_q  [DEPTH];
    logic [FILL_W-1:0] fill;

    always_comb begin
        res = '0;
        for (int i = 0; i < WIDTH; i++)
            res[i] = resolve_lane(d[i], s[i], r[i]);
    end

    assign conf_v = s & r;
    assign conf   = |conf_v;

    assign stage_in[0] = res;

    genvar k;
    generate
        for (k = 1; k < DEPTH; k++) begin : g_link
            assign stage_in[k] = stage_q[k-1];
        end
        for (k = 0; k < DEPTH; k++) begin : g_stage
            dff_sr_stage #(.WIDTH(WIDTH)) u_stage (
                .clk   (clk),
                .rst_n (rst_n),
                .en    (en),
                .d     (stage_in[k]),
                .q     (stage_q[k])
            );
        end
    endgenerate

    assign q     = stage_q[DEPTH-1];
    assign q_vld = (fill == FILL_W'(DEPTH));

    // fill counts enabled edges since reset and parks at DEPTH
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n)
            fill <= '0;
        else if (en && !q_vld)
            fill <= fill + 1'b1;

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            err     <= 1'b0;
            err_cnt <= '0;
        end else begin
            err     <= en & conf;
            err_cnt <= err_clr ? '0 :
                       (en && conf && err_cnt != CNT_MAX) ? err_cnt + 1'b1 : err_cnt;
        end

`ifdef DFF_SR_PIPE_ERR_MASK_EN
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n)
            err_mask <= '0;
        else
            err_mask <= err_clr ? '0 : (en ? (err_mask | conf_v) : err_mask);
`endif
endmodule

// File: tb/tb_dff_sr_pipe.sv
// tb_dff_sr_pipe: randomized + directed scoreboard bench for dff_sr_pipe (WIDTH=8, DEPTH=3, ERR_CNT_W=2)
module tb_dff_sr_pipe;
    localparam int W  = 8;
    localparam int DP = 3;
    localparam int CW = 2;

    typedef struct {
        logic [W-1:0]  q;
        logic          vld;
        logic          err;
        logic [CW-1:0] cnt;
        logic [W-1:0]  mask;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          en = 1'b0;
    logic [W-1:0]  d = '0, s = '0, r = '0;
    logic          err_clr = 1'b0;
    logic [W-1:0]  q;
    logic          q_vld;
    logic          err;
    logic [CW-1:0] err_cnt;
    logic [W-1:0]  err_mask;

    int checks = 0;
    int errors = 0;

    exp_t          exp_q[$];
    logic [W-1:0]  hist[$];
    int            m_cnt = 0;
    logic [W-1:0]  m_mask = '0;

    dff_sr_pipe #(.WIDTH(W), .DEPTH(DP), .ERR_CNT_W(CW)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .en      (en),
        .d       (d),
        .s       (s),
        .r       (r),
        .err_clr (err_clr),
        .q       (q),
        .q_vld   (q_vld),
        .err     (err),
        .err_cnt (err_cnt)
`ifdef DFF_SR_PIPE_ERR_MASK_EN
        ,
        .err_mask(err_mask)
`endif
    );

`ifndef DFF_SR_PIPE_ERR_MASK_EN
    assign err_mask = '0;
`endif

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
        checks++;
        if (act !== want) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, want, $time);
        end
    endtask

    // reference: q is the resolved value sampled DEPTH enabled edges back, zero until then
    task automatic drive(input logic e, input logic [W-1:0] dd, input logic [W-1:0] ss,
                         input logic [W-1:0] rr, input logic clr);
        exp_t x;
        logic [W-1:0] c;
        @(negedge clk);
        en = e; d = dd; s = ss; r = rr; err_clr = clr;
        c = ss & rr;
        if (e) begin
            hist.push_back((dd | ss) & ~rr);
            if (hist.size() > DP) void'(hist.pop_front());
        end
        if (clr) m_cnt = 0;
        else if (e && c != 0) m_cnt = (m_cnt + 1 > 3) ? 3 : m_cnt + 1;
        if (clr) m_mask = '0;
        else if (e) m_mask = m_mask | c;
        x.vld  = (hist.size() == DP);
        x.q    = x.vld ? hist[0] : '0;
        x.err  = e && (c != 0);
        x.cnt  = CW'(m_cnt);
        x.mask = m_mask;
        exp_q.push_back(x);
    endtask

    always @(posedge clk) begin
        exp_t x;
        #1;
        if (exp_q.size() > 0) begin
            x = exp_q.pop_front();
            check("q", 32'(q), 32'(x.q));
            check("q_vld", 32'(q_vld), 32'(x.vld));
            check("err", 32'(err), 32'(x.err));
            check("err_cnt", 32'(err_cnt), 32'(x.cnt));
`ifdef DFF_SR_PIPE_ERR_MASK_EN
            check("err_mask", 32'(err_mask), 32'(x.mask));
`endif
        end
    end

    task automatic async_reset();
        @(negedge clk);
        en = 1'b0; err_clr = 1'b0;
        #1 rst_n = 1'b0;
        #1;
        check("rst_q", 32'(q), 0);
        check("rst_q_vld", 32'(q_vld), 0);
        check("rst_err_cnt", 32'(err_cnt), 0);
        check("rst_err", 32'(err), 0);
        hist.delete();
        m_cnt = 0;
        m_mask = '0;
        #1 rst_n = 1'b1;
    endtask

    initial begin
        logic [W-1:0] rs, rr;
        repeat (2) @(negedge clk);
        check("init_q", 32'(q), 0);
        check("init_q_vld", 32'(q_vld), 0);
        rst_n = 1'b1;
        // latency
        drive(1, 8'hA5, 0, 0, 0);
        drive(1, 8'h3C, 0, 0, 0);
        drive(1, 8'h00, 0, 0, 0);
        drive(1, 8'h11, 0, 0, 0);
        // priority
        drive(1, 8'h00, 8'hFF, 8'h0F, 0);
        repeat (3) drive(1, 8'h00, 0, 0, 0);
        // hold with conflicting s/r
        repeat (5) drive(0, 8'h5A, 8'hFF, 8'hFF, 0);
        // saturation then clear coinciding with conflict
        repeat (5) drive(1, 8'h00, 8'h01, 8'h01, 0);
        drive(1, 8'h00, 8'h02, 8'h02, 1);
        drive(1, 8'h00, 0, 0, 0);
        // sticky mask lanes 0 then 7
        drive(1, 8'h00, 8'h01, 8'h01, 0);
        drive(1, 8'h00, 8'h80, 8'h80, 0);
        drive(0, 8'h00, 0, 0, 0);
        drive(0, 8'h00, 0, 0, 1);
        // reset with pipe full
        async_reset();
        repeat (2) drive(1, 8'hC3, 0, 0, 0);
        for (int n = 0; n < 400; n++) begin
            rs = W'($urandom & $urandom & $urandom);
            rr = W'($urandom & $urandom);
            drive(($urandom_range(3) != 0), W'($urandom), rs, rr, ($urandom_range(15) == 0));
            if (n == 200) async_reset();
        end
        drive(0, 0, 0, 0, 0);
        repeat (3) @(negedge clk);
        check("scoreboard_drained", 32'(exp_q.size()), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1, "timeout");
    end
endmodule
